// File: rtl/tmds_word_packer.sv
// -----------------------------------------------------------------------------
// tmds_word_packer
//   Gathers PIX_PER_WORD consecutive per-channel TMDS symbols into one wide
//   transceiver word and buffers the words in a single-clock FIFO that is
//   presented first-word-fall-through on a valid/ready interface.
//   In fill_idle mode the output is always valid and underruns are filled
//   with a word made of IDLE_SYM in every slot.
//
// Ports
//   clk_pixel         pixel clock, all logic on the rising edge
//   clk_pixel_resetn  asynchronous active-low reset
//   sym_in            one symbol per channel, channel c at [c*SYM_W +: SYM_W]
//   sym_valid         sym_in valid this cycle
//   sym_sof           with sym_valid: this symbol set is slot 0 (realign)
//   fill_idle         1 = idle-fill on underrun, 0 = plain valid/ready
//   clr_stats         synchronous clear of counters and align_err
//   word_out          packed word, channel c / slot p at
//                     [(c*PIX_PER_WORD+p)*SYM_W +: SYM_W]
//   word_valid        word_out valid
//   word_ready        consumer accepts word_out
//   level             FIFO occupancy
//   overflow_cnt      dropped words, saturating
//   underflow_cnt     ready cycles with an empty FIFO, saturating
//   align_err         sticky: sof arrived with slot != 0
// -----------------------------------------------------------------------------
module tmds_word_packer #(
    parameter int unsigned      NUM_CH       = 3,
    parameter int unsigned      SYM_W        = 10,
    parameter int unsigned      PIX_PER_WORD = 2,
    parameter int unsigned      FIFO_DEPTH   = 8,
    parameter logic [SYM_W-1:0] IDLE_SYM     = 10'h354
) (
    input  logic                                   clk_pixel,
    input  logic                                   clk_pixel_resetn,
    input  logic [NUM_CH*SYM_W-1:0]                sym_in,
    input  logic                                   sym_valid,
    input  logic                                   sym_sof,
    input  logic                                   fill_idle,
    input  logic                                   clr_stats,
    output logic [NUM_CH*SYM_W*PIX_PER_WORD-1:0]   word_out,
    output logic                                   word_valid,
    input  logic                                   word_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        level,
    output logic [15:0]                            overflow_cnt,
    output logic [15:0]                            underflow_cnt,
    output logic                                   align_err
);

    localparam int unsigned WW = NUM_CH * SYM_W * PIX_PER_WORD;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    localparam logic [SW-1:0] LAST_SLOT = SW'(PIX_PER_WORD - 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [WW-1:0] IDLE_WORD = {(NUM_CH * PIX_PER_WORD){IDLE_SYM}};

    logic [SW-1:0] slot_q, slot_d, base_slot;
    logic [WW-1:0] asm_q, asm_d;
    logic [WW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [WW-1:0] hold_q, hold_d;
    logic [15:0]   ovf_q, ovf_d;
    logic [15:0]   udf_q, udf_d;
    logic          align_q, align_d;

    logic          empty, full, pop, push_req, push_ok;
    logic [WW-1:0] head;

    // ---------------------------------------------------------------------
    // Word assembly: merge this cycle's symbols into the slot being filled.
    // A sof forces slot 0, so the partial word is simply overwritten.
    // ---------------------------------------------------------------------
    always_comb begin
        base_slot = sym_sof ? '0 : slot_q;
        asm_d     = asm_q;
        slot_d    = slot_q;
        push_req  = 1'b0;
        if (sym_valid) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned p = 0; p < PIX_PER_WORD; p++) begin
                    if (SW'(p) == base_slot) begin
                        asm_d[(c*PIX_PER_WORD + p)*SYM_W +: SYM_W] = sym_in[c*SYM_W +: SYM_W];
                    end
                end
            end
            push_req = (base_slot == LAST_SLOT);
            slot_d   = push_req ? '0 : base_slot + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // FIFO control. A pop on an empty FIFO is never performed, so a push
    // into an empty FIFO always lands; a full FIFO accepts a push only when
    // the head leaves in the same cycle.
    // ---------------------------------------------------------------------
    always_comb begin
        empty   = (level_q == '0);
        full    = (level_q == DEPTH_L);
        head    = mem_q[rd_ptr_q];
        pop     = word_ready && !empty;
        push_ok = push_req && (!full || pop);

        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push_ok) begin
            level_d = level_q - 1'b1;
        end

        // Remember what was shown so an empty FIFO keeps presenting it.
        hold_d = empty ? hold_q : head;
    end

    // ---------------------------------------------------------------------
    // Statistics: clr_stats wins over any same-cycle increment or set.
    // ---------------------------------------------------------------------
    always_comb begin
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        align_d = align_q;
        if (clr_stats) begin
            ovf_d   = '0;
            udf_d   = '0;
            align_d = 1'b0;
        end else begin
            if (push_req && !push_ok && (ovf_q != '1)) begin
                ovf_d = ovf_q + 1'b1;
            end
            if (word_ready && empty && (udf_q != '1)) begin
                udf_d = udf_q + 1'b1;
            end
            if (sym_valid && sym_sof && (slot_q != '0)) begin
                align_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge clk_pixel_resetn) begin
        if (!clk_pixel_resetn) begin
            slot_q   <= '0;
            asm_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hold_q   <= '0;
            ovf_q    <= '0;
            udf_q    <= '0;
            align_q  <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            asm_q    <= asm_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hold_q   <= hold_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            align_q  <= align_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_pixel) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= asm_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs. word_out is forced to zero while reset is asserted, which
    // also masks the idle word when fill_idle is high during reset.
    // ---------------------------------------------------------------------
    always_comb begin
        word_valid = fill_idle || !empty;
        if (!clk_pixel_resetn) begin
            word_out = '0;
        end else if (!empty) begin
            word_out = head;
        end else if (fill_idle) begin
            word_out = IDLE_WORD;
        end else begin
            word_out = hold_q;
        end
    end

    assign level         = level_q;
    assign overflow_cnt  = ovf_q;
    assign underflow_cnt = udf_q;
    assign align_err     = align_q;

endmodule

// File: tb/tb_tmds_word_packer.sv
module tb_tmds_word_packer;

    localparam int unsigned NCH   = 3;
    localparam int unsigned SW    = 10;
    localparam int unsigned PPW   = 2;
    localparam int unsigned DEPTH = 8;
    localparam logic [59:0] IDLE  = {6{10'h354}};

    logic        clk;
    logic        rst_n;
    logic [29:0] sym_in;
    logic        sym_valid;
    logic        sym_sof;
    logic        fill_idle;
    logic        clr_stats;
    logic [59:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [3:0]  level;
    logic [15:0] overflow_cnt;
    logic [15:0] underflow_cnt;
    logic        align_err;

    tmds_word_packer #(
        .NUM_CH      (NCH),
        .SYM_W       (SW),
        .PIX_PER_WORD(PPW),
        .FIFO_DEPTH  (DEPTH),
        .IDLE_SYM    (10'h354)
    ) dut (
        .clk_pixel       (clk),
        .clk_pixel_resetn(rst_n),
        .sym_in          (sym_in),
        .sym_valid       (sym_valid),
        .sym_sof         (sym_sof),
        .fill_idle       (fill_idle),
        .clr_stats       (clr_stats),
        .word_out        (word_out),
        .word_valid      (word_valid),
        .word_ready      (word_ready),
        .level           (level),
        .overflow_cnt    (overflow_cnt),
        .underflow_cnt   (underflow_cnt),
        .align_err       (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [29:0] set_a;
        logic [29:0] set_b;
        logic [59:0] exp_word;
    } vec_t;

    vec_t tbl [4];

    // Reference model state
    int          m_slot;
    logic [29:0] m_sets [2];
    logic [59:0] m_q [$];
    logic [59:0] m_last;
    int          m_ovf;
    int          m_udf;
    bit          m_align;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing: symbol of channel c from set p lands at slot index c*PPW+p.
    function automatic logic [59:0] pack(input logic [29:0] a, input logic [29:0] b);
        logic [59:0] w;
        w = '0;
        for (int c = 0; c < 3; c++) begin
            w = w | (60'(a[c*10 +: 10]) << ((c*2 + 0) * 10));
            w = w | (60'(b[c*10 +: 10]) << ((c*2 + 1) * 10));
        end
        return w;
    endfunction

    function automatic logic [29:0] rnd_set();
        return {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [29:0] s, input logic sof);
        sym_in    = s;
        sym_valid = 1'b1;
        sym_sof   = sof;
        tick();
        sym_valid = 1'b0;
        sym_sof   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        sym_valid  = 1'b0;
        sym_sof    = 1'b0;
        clr_stats  = 1'b0;
        word_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic model_reset();
        m_slot  = 0;
        m_sets[0] = '0;
        m_sets[1] = '0;
        m_q.delete();
        m_last  = '0;
        m_ovf   = 0;
        m_udf   = 0;
        m_align = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the currently driven inputs.
    task automatic model_step();
        bit emp;
        bit pop;
        bit accept;
        bit ovf_inc;
        bit udf_inc;
        bit al_set;
        int pre_size;
        pre_size = m_q.size();
        emp      = (pre_size == 0);
        pop      = word_ready && !emp;
        accept   = (pre_size < DEPTH) || pop;
        ovf_inc  = 1'b0;
        udf_inc  = word_ready && emp;
        al_set   = 1'b0;
        if (!emp) m_last = m_q[0];
        if (pop) void'(m_q.pop_front());
        if (sym_valid) begin
            if (sym_sof) begin
                if (m_slot != 0) al_set = 1'b1;
                m_slot = 0;
            end
            m_sets[m_slot] = sym_in;
            if (m_slot == PPW - 1) begin
                if (accept) m_q.push_back(pack(m_sets[0], m_sets[1]));
                else        ovf_inc = 1'b1;
            end
            m_slot = (m_slot + 1) % PPW;
        end
        if (clr_stats) begin
            m_ovf   = 0;
            m_udf   = 0;
            m_align = 1'b0;
        end else begin
            if (ovf_inc && m_ovf < 16'hFFFF) m_ovf++;
            if (udf_inc && m_udf < 16'hFFFF) m_udf++;
            if (al_set) m_align = 1'b1;
        end
    endtask

    task automatic model_check();
        logic [59:0] exp_out;
        if (m_q.size() > 0) exp_out = m_q[0];
        else if (fill_idle) exp_out = IDLE;
        else exp_out = m_last;
        chk("rnd_valid", 64'(word_valid), 64'(fill_idle || (m_q.size() > 0)));
        chk("rnd_word",  64'(word_out), 64'(exp_out));
        chk("rnd_level", 64'(level), 64'(m_q.size()));
        chk("rnd_ovf",   64'(overflow_cnt), 64'(m_ovf));
        chk("rnd_udf",   64'(underflow_cnt), 64'(m_udf));
        chk("rnd_align", 64'(align_err), 64'(m_align));
    endtask

    logic [59:0] exp_w [10];
    logic [29:0] sa, sb, s1, s2, s3;

    initial begin
        tbl[0] = '{30'({10'h003, 10'h002, 10'h001}), 30'({10'h013, 10'h012, 10'h011}),
                   {10'h013, 10'h003, 10'h012, 10'h002, 10'h011, 10'h001}};
        tbl[1] = '{30'({10'h3FF, 10'h000, 10'h155}), 30'({10'h2AA, 10'h001, 10'h200}),
                   {10'h2AA, 10'h3FF, 10'h001, 10'h000, 10'h200, 10'h155}};
        tbl[2] = '{30'({10'h0F0, 10'h30F, 10'h1E1}), 30'({10'h00F, 10'h3C3, 10'h2D2}),
                   {10'h00F, 10'h0F0, 10'h3C3, 10'h30F, 10'h2D2, 10'h1E1}};
        tbl[3] = '{30'({10'h3FF, 10'h3FF, 10'h3FF}), 30'({10'h000, 10'h000, 10'h000}),
                   {10'h000, 10'h3FF, 10'h000, 10'h3FF, 10'h000, 10'h3FF}};

        sym_in     = '0;
        sym_valid  = 1'b0;
        sym_sof    = 1'b0;
        fill_idle  = 1'b0;
        clr_stats  = 1'b0;
        word_ready = 1'b0;
        rst_n      = 1'b0;

        // Reset state
        #12;
        chk("rst_valid_fi0", 64'(word_valid), 64'(0));
        chk("rst_word_fi0", 64'(word_out), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_ovf", 64'(overflow_cnt), 64'(0));
        chk("rst_udf", 64'(underflow_cnt), 64'(0));
        chk("rst_align", 64'(align_err), 64'(0));
        fill_idle = 1'b1;
        #1;
        chk("rst_valid_fi1", 64'(word_valid), 64'(1));
        chk("rst_word_fi1", 64'(word_out), 64'(0));
        fill_idle = 1'b0;
        do_reset();

        // Table-driven packing with ready=1
        word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            feed(tbl[i].set_a, 1'b0);
            chk("tbl_valid_lo", 64'(word_valid), 64'(0));
            feed(tbl[i].set_b, 1'b0);
            chk("tbl_valid_hi", 64'(word_valid), 64'(1));
            chk("tbl_word", 64'(word_out), 64'(tbl[i].exp_word));
        end
        tick();
        chk("tbl_drained", 64'(word_valid), 64'(0));
        chk("tbl_hold", 64'(word_out), 64'(tbl[3].exp_word));

        // Overflow: 9 words into a stalled FIFO, then drain in order
        do_reset();
        for (int k = 0; k < 9; k++) begin
            sa = rnd_set();
            sb = rnd_set();
            exp_w[k] = pack(sa, sb);
            feed(sa, 1'b0);
            feed(sb, 1'b0);
        end
        chk("ovf_level", 64'(level), 64'(8));
        chk("ovf_cnt", 64'(overflow_cnt), 64'(1));
        word_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("ovf_drain_valid", 64'(word_valid), 64'(1));
            chk("ovf_drain_word", 64'(word_out), 64'(exp_w[k]));
            tick();
        end
        chk("ovf_drain_empty", 64'(word_valid), 64'(0));
        chk("ovf_drain_hold", 64'(word_out), 64'(exp_w[7]));

        // Full FIFO, pop and final-slot push in the same cycle
        do_reset();
        for (int k = 0; k < 8; k++) begin
            sa = rnd_set();
            sb = rnd_set();
            exp_w[k] = pack(sa, sb);
            feed(sa, 1'b0);
            feed(sb, 1'b0);
        end
        sa = rnd_set();
        sb = rnd_set();
        exp_w[8] = pack(sa, sb);
        feed(sa, 1'b0);
        word_ready = 1'b1;
        feed(sb, 1'b0);
        word_ready = 1'b0;
        chk("full_pp_level", 64'(level), 64'(8));
        chk("full_pp_ovf", 64'(overflow_cnt), 64'(0));
        word_ready = 1'b1;
        for (int k = 1; k < 9; k++) begin
            chk("full_pp_word", 64'(word_out), 64'(exp_w[k]));
            tick();
        end
        chk("full_pp_empty", 64'(level), 64'(0));

        // clr_stats wins over a same-cycle overflow
        do_reset();
        for (int k = 0; k < 9; k++) begin
            feed(rnd_set(), 1'b0);
            feed(rnd_set(), 1'b0);
        end
        chk("clr_pre_ovf", 64'(overflow_cnt), 64'(1));
        feed(rnd_set(), 1'b0);
        clr_stats = 1'b1;
        feed(rnd_set(), 1'b0);
        clr_stats = 1'b0;
        chk("clr_ovf", 64'(overflow_cnt), 64'(0));
        chk("clr_level", 64'(level), 64'(8));

        // Idle fill on underrun
        do_reset();
        fill_idle  = 1'b1;
        word_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_valid", 64'(word_valid), 64'(1));
            chk("idle_word", 64'(word_out), 64'(IDLE));
        end
        chk("idle_udf", 64'(underflow_cnt), 64'(5));
        word_ready = 1'b0;
        fill_idle  = 1'b0;

        // Underflow saturation, then clear while still counting
        word_ready = 1'b1;
        for (int k = 0; k < 65540; k++) tick();
        chk("udf_sat", 64'(underflow_cnt), 64'(16'hFFFF));
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("udf_clr", 64'(underflow_cnt), 64'(0));
        word_ready = 1'b0;

        // Realignment via sof mid-word
        do_reset();
        s1 = rnd_set();
        s2 = rnd_set();
        s3 = rnd_set();
        feed(s1, 1'b0);
        feed(s2, 1'b1);
        chk("align_set", 64'(align_err), 64'(1));
        chk("align_nopush", 64'(level), 64'(0));
        feed(s3, 1'b0);
        chk("align_level", 64'(level), 64'(1));
        chk("align_word", 64'(word_out), 64'(pack(s2, s3)));
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("align_clr", 64'(align_err), 64'(0));
        feed(s1, 1'b1);
        chk("align_sof_slot0", 64'(align_err), 64'(0));
        feed(s2, 1'b0);
        chk("align_word2_level", 64'(level), 64'(2));

        // Reset asserted mid-packing
        do_reset();
        feed(rnd_set(), 1'b0);
        feed(rnd_set(), 1'b0);
        feed(rnd_set(), 1'b0);
        fill_idle = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 64'(level), 64'(0));
        chk("mid_rst_valid1", 64'(word_valid), 64'(1));
        chk("mid_rst_word", 64'(word_out), 64'(0));
        fill_idle = 1'b0;
        #1;
        chk("mid_rst_valid0", 64'(word_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        sa = rnd_set();
        sb = rnd_set();
        feed(sa, 1'b0);
        chk("mid_rst_slot0", 64'(level), 64'(0));
        feed(sb, 1'b0);
        chk("mid_rst_push", 64'(level), 64'(1));
        chk("mid_rst_word2", 64'(word_out), 64'(pack(sa, sb)));

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            sym_valid  = ($urandom_range(0, 9) < 7);
            sym_sof    = sym_valid && ($urandom_range(0, 15) == 0);
            sym_in     = rnd_set();
            word_ready = (n < 750) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 31) == 0) fill_idle = ~fill_idle;
            clr_stats  = ($urandom_range(0, 49) == 0);
            model_step();
            tick();
            model_check();
        end
        sym_valid  = 1'b0;
        sym_sof    = 1'b0;
        clr_stats  = 1'b0;
        word_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
